// File: rtl/cu_reg_responder.sv
// Operand-request responder: 8 x XLEN register bank whose selected entry is
// returned serially (LSB first) on cu_dataout, followed by a cu_done pulse.
module cu_reg_responder #(
    parameter int unsigned XLEN    = 16,
    parameter logic [1:0]  CHIP_ID = 2'b00
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_data,
    input  logic [2:0]      addr,
    input  logic [1:0]      chip_sel,
    input  logic            wr_en,
    input  logic [2:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic            cu_dataout,
    output logic            cu_done,
    output logic            busy
);

    localparam int unsigned CW = (XLEN > 2) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(XLEN - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [XLEN-1:0] regs [8];

    logic [1:0]      state, state_n;
    logic [XLEN-1:0] shreg, shreg_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            armed, armed_n;
    logic            dout_n, done_n, busy_n;
    logic            accept;
    logic [XLEN-1:0] snap_word;

    // Register bank; writes land in any FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Same-cycle write to the requested index wins over the stored value.
    assign snap_word = (wr_en && (wr_addr == addr)) ? wr_data : regs[addr];
    assign accept    = (state == S_IDLE) && req_data && (chip_sel == CHIP_ID) && armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            armed      <= 1'b1;
            cu_dataout <= 1'b0;
            cu_done    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            cnt        <= cnt_n;
            armed      <= armed_n;
            cu_dataout <= dout_n;
            cu_done    <= done_n;
            busy       <= busy_n;
        end
    end

    // Next-state logic; output flops are loaded one edge ahead so that the
    // registered cu_dataout shows bit k in the cycle after edge E0+k.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        armed_n = armed;
        dout_n  = 1'b0;
        done_n  = 1'b0;
        busy_n  = 1'b0;

        if (!req_data) begin
            armed_n = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_SHIFT;
                    shreg_n = snap_word;
                    cnt_n   = '0;
                    armed_n = 1'b0;
                    dout_n  = snap_word[0];
                    busy_n  = 1'b1;
                end
            end
            S_SHIFT: begin
                busy_n  = 1'b1;
                shreg_n = shreg >> 1;
                if (cnt == LAST_BIT) begin
                    state_n = S_DONE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end else begin
                    cnt_n  = cnt + CW'(1);
                    dout_n = shreg[1];
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule
